// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int NREQ = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Width comes from the low two funct3 bits; anything not byte/half is a word.
  function automatic logic is_misaligned(input logic [1:0] f3_size, input logic [1:0] a_low);
    logic mis;
    case (f3_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = a_low[0];
      default: mis = (a_low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU and a debug/DMA port,
// one access every three cycles (IDLE grant, ISSUE strobe, RESP reply).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [2*DM_ADDRESS-1:0] addr,
  input  logic [2*DATA_W-1:0]     wdata,
  input  logic [5:0]              funct3,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DM_ADDRESS-1:0]   mem_a,
  output logic [DATA_W-1:0]       mem_wd,
  output logic [2:0]              mem_funct3,
  input  logic [DATA_W-1:0]       mem_rd
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;

  logic [1:0] grant;
  logic       win;
  logic       mis;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  assign win = grant[1];
  assign mis = is_misaligned(f3_q[1:0], addr_q[1:0]);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    gnt       = '0;
    rvalid    = '0;
    err       = 1'b0;
    rdata     = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          gnt     = grant;
          last_d  = win;
          sel_d   = win;
          we_d    = we[win];
          addr_d  = win ? addr[2*DM_ADDRESS-1:DM_ADDRESS] : addr[DM_ADDRESS-1:0];
          wdata_d = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          f3_d    = win ? funct3[5:3] : funct3[2:0];
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (!mis) begin
          mem_read  = !we_q;
          mem_write = we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        rvalid  = sel_q ? 2'b10 : 2'b01;
        err     = mis;
        rdata   = (!we_q && !mis) ? mem_rd : '0;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so outputs are forced quiet while it is held.
    if (!rst_n) begin
      gnt       = '0;
      rvalid    = '0;
      err       = 1'b0;
      rdata     = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign mem_a      = rst_n ? addr_q  : '0;
  assign mem_wd     = rst_n ? wdata_q : '0;
  assign mem_funct3 = rst_n ? f3_q    : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [5:0]    funct3 = '0;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          err, mem_read, mem_write;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rd = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .err        (err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_funct3 (mem_funct3),
    .mem_rd     (mem_rd)
  );

  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] data;
    logic          e;
    int            cyc;
  } resp_t;

  resp_t sbQ[$];
  int    checks = 0;
  int    errors = 0;
  int    cycleNum = 0;
  logic  lastServed = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] modelGrant(input logic [1:0] r, input logic last);
    if (r == 2'b11) return last ? 2'b01 : 2'b10;
    return r;
  endfunction

  function automatic logic modelMis(input logic [2:0] f3, input logic [AW-1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a[1:0] != 2'b00;
    endcase
  endfunction

  task automatic applyStimulus(input int r, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [2:0] f3);
    we[r]              = w;
    addr[r*AW +: AW]   = a;
    wdata[r*DW +: DW]  = d;
    funct3[r*3 +: 3]   = f3;
    req[r]             = 1'b1;
  endtask

  // Advance one cycle and pop the scoreboard whenever a response shows up.
  task automatic cyc();
    resp_t r;
    @(posedge clk);
    #1;
    cycleNum++;
    if (rvalid !== 2'b00) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRvalid", {62'd0, rvalid}, 64'd0);
      end else begin
        r = sbQ.pop_front();
        checkOutput("rvalid", {62'd0, rvalid}, {62'd0, r.rv});
        checkOutput("rdata", {32'd0, rdata}, {32'd0, r.data});
        checkOutput("err", {63'd0, err}, {63'd0, r.e});
        checkOutput("rvalidCycle", cycleNum, r.cyc);
      end
    end else begin
      checkOutput("errNoRvalid", {63'd0, err}, 64'd0);
    end
  endtask

  // One full access from the current IDLE cycle; req is left as the caller set it.
  task automatic runAccess(input string tag);
    logic [1:0]    eg;
    int            w;
    logic          ew, mis;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [2:0]    ef;
    resp_t         r;
    #1;
    eg = modelGrant(req, lastServed);
    checkOutput({tag, "_gnt"}, {62'd0, gnt}, {62'd0, eg});
    w  = eg[1] ? 1 : 0;
    ew = we[w];
    ea = addr[w*AW +: AW];
    ed = wdata[w*DW +: DW];
    ef = funct3[w*3 +: 3];
    mis = modelMis(ef, ea);
    r.rv   = eg;
    r.data = (ew || mis) ? '0 : mem_rd;
    r.e    = mis;
    r.cyc  = cycleNum + 2;
    sbQ.push_back(r);
    lastServed = eg[1];
    cyc();
    checkOutput({tag, "_memRead"}, {63'd0, mem_read}, {63'd0, (!ew && !mis)});
    checkOutput({tag, "_memWrite"}, {63'd0, mem_write}, {63'd0, (ew && !mis)});
    checkOutput({tag, "_memA"}, {55'd0, mem_a}, {55'd0, ea});
    checkOutput({tag, "_memWd"}, {32'd0, mem_wd}, {32'd0, ed});
    checkOutput({tag, "_memF3"}, {61'd0, mem_funct3}, {61'd0, ef});
    checkOutput({tag, "_gntIssue"}, {62'd0, gnt}, 64'd0);
    cyc();
    checkOutput({tag, "_strobesResp"}, {62'd0, mem_read, mem_write}, 64'd0);
    cyc();
  endtask

  initial begin
    // Reset held with both requesters active: everything must stay quiet.
    mem_rd = 32'hCAFE_F00D;
    applyStimulus(0, 1'b0, 9'h020, 32'h0, F3_LW);
    applyStimulus(1, 1'b0, 9'h024, 32'h0, F3_LW);
    cyc();
    cyc();
    checkOutput("rstGnt", {62'd0, gnt}, 64'd0);
    checkOutput("rstStrobes", {62'd0, mem_read, mem_write}, 64'd0);
    checkOutput("rstRdata", {32'd0, rdata}, 64'd0);
    checkOutput("rstMemA", {55'd0, mem_a}, 64'd0);
    checkOutput("rstMemWd", {32'd0, mem_wd}, 64'd0);
    checkOutput("rstMemF3", {61'd0, mem_funct3}, 64'd0);
    lastServed = 1'b1;
    rst_n = 1'b1;

    // Simultaneous requests held across two accesses.
    mem_rd = 32'h1111_2222;
    runAccess("sim0");
    mem_rd = 32'h3333_4444;
    runAccess("sim1");
    req = '0;

    // Single aligned load from the LSU.
    mem_rd = 32'hDEAD_BEEF;
    applyStimulus(0, 1'b0, 9'h010, 32'h0, F3_LW);
    runAccess("load");
    req = '0;

    // Halfword store from the debug port.
    applyStimulus(1, 1'b1, 9'h004, 32'h1234_5678, F3_SH);
    runAccess("store");
    req = '0;

    // Alignment boundaries.
    mem_rd = 32'h0BAD_0BAD;
    applyStimulus(0, 1'b0, 9'h006, 32'h0, F3_LW);
    runAccess("misLw");
    req = '0;
    applyStimulus(0, 1'b0, 9'h006, 32'h0, F3_LH);
    runAccess("okLh");
    req = '0;
    applyStimulus(1, 1'b1, 9'h002, 32'hA5A5_A5A5, 3'b011);
    runAccess("misUnknown");
    req = '0;
    applyStimulus(1, 1'b0, 9'h003, 32'h0, F3_LBU);
    runAccess("okLbu");
    req = '0;
    applyStimulus(0, 1'b0, 9'h00D, 32'h0, F3_LHU);
    runAccess("misLhu");
    req = '0;

    // Reset during ISSUE abandons the load and restores requester 0 priority.
    applyStimulus(0, 1'b0, 9'h030, 32'h0, F3_LW);
    #1;
    checkOutput("abortGnt", {62'd0, gnt}, 64'd1);
    cyc();
    req = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("abortStrobes", {62'd0, mem_read, mem_write}, 64'd0);
    cyc();
    rst_n = 1'b1;
    lastServed = 1'b1;
    #1;
    checkOutput("postRstStrobes", {62'd0, mem_read, mem_write}, 64'd0);
    cyc();
    cyc();
    mem_rd = 32'h5555_AAAA;
    applyStimulus(0, 1'b0, 9'h040, 32'h0, F3_LW);
    applyStimulus(1, 1'b1, 9'h044, 32'h7777_8888, F3_SW);
    runAccess("postRst0");
    runAccess("postRst1");
    req = '0;

    cyc();
    checkOutput("sbEmpty", sbQ.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
